// File: rtl/bin2bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
// One input bit is consumed per cycle in OP. Results are presented with a
// start/ready/done_tick handshake.
module bin2bcd #(
  parameter int BIN_WIDTH = 7,
  parameter int DIGITS    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin,
  output logic                 ready,
  output logic                 done_tick,
  output logic [3:0]           bcd0,
  output logic [3:0]           bcd1,
  output logic [3:0]           bcd2
);

  localparam int DW   = 4 * DIGITS;
  localparam int CW   = $clog2(BIN_WIDTH + 1);
  localparam int OUTW = (DIGITS > 3) ? DW : 12;

  typedef enum logic [1:0] {
    IDLE,
    OP,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] sr_q, sr_d;
  logic [DW-1:0]        digits_q, digits_d;
  logic [DW-1:0]        adj;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [OUTW-1:0]      digits_ext;

  // State, shift register, digits and bit counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      digits_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
    end
  end

  // Add 3 to every digit above 4 before the shift (4-bit, no carry out)
  always_comb begin
    adj = digits_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (digits_q[4*i +: 4] > 4'd4) begin
        adj[4*i +: 4] = digits_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    digits_d = digits_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d     = bin;
          digits_d = '0;
          cnt_d    = CW'(BIN_WIDTH);
          state_d  = OP;
        end
      end
      OP: begin
        // MSB of the shift register enters bit 0 of the ones digit
        {digits_d, sr_d} = {adj, sr_q} << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from state; digits zero-extended to three nibbles
  always_comb begin
    ready      = (state_q == IDLE);
    done_tick  = (state_q == DONE);
    digits_ext = OUTW'(digits_q);
    bcd0       = digits_ext[3:0];
    bcd1       = digits_ext[7:4];
    bcd2       = digits_ext[11:8];
  end

endmodule
